pixel_scan_issuer: RTL and testbench

Raster-order pixel coordinate generator that drives `eye_to_pixel`. It walks a WIDTH×HEIGHT frame and emits one (x, y) per cycle. A credit counter bounds how many pixels are in flight in the downstream ray pipeline. The consumer at the end of the ray pipeline returns one credit per finished pixel, so no pipeline stage needs backpressure. It signals frame completion only after every issued pixel has been retired.

---
 rtl/pixel_scan_issuer.sv | 97 +++++++++
 tb/tb_pixel_scan_issuer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scan_issuer.sv
// Raster-order (x, y) issuer for eye_to_pixel, throttled by a downstream credit pool.
// Optional macro PIXEL_SCAN_LOOP_EN: restart the next frame automatically after frame_done_out.
module pixel_scan_issuer #(
    parameter int WIDTH        = 512,
    parameter int HEIGHT       = 384,
    parameter int MAX_INFLIGHT = 128
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        credit_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic [7:0]  credits_out
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [10:0] X_LAST   = 11'(WIDTH - 1);
    localparam logic [9:0]  Y_LAST   = 10'(HEIGHT - 1);
    localparam logic [7:0]  CRED_MAX = 8'(MAX_INFLIGHT);

    state_t      state, state_next;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic [7:0]  credits_next;
    logic        issue, last_pix, cred_full, restart, overflow_hit;
    logic        credit_overflow;

    always_comb begin
        issue        = (state == SCAN) && (credits_out != 8'd0);
        last_pix     = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
        cred_full    = (credits_out == CRED_MAX);
        overflow_hit = !issue && credit_in && cred_full;
`ifdef PIXEL_SCAN_LOOP_EN
        // frame_done_out is high only during the single IDLE cycle after DRAIN
        restart      = start_in || frame_done_out;
`else
        restart      = start_in;
`endif

        credits_next = credits_out;
        if (issue && !credit_in)
            credits_next = credits_out - 8'd1;
        else if (!issue && credit_in && !cred_full)
            credits_next = credits_out + 8'd1;

        state_next = state;
        case (state)
            IDLE:    if (restart) state_next = SCAN;
            SCAN:    if (issue && last_pix) state_next = DRAIN;
            DRAIN:   if (cred_full) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            x_cnt           <= '0;
            y_cnt           <= '0;
            credits_out     <= CRED_MAX;
            x_out           <= '0;
            y_out           <= '0;
            valid_out       <= 1'b0;
            busy_out        <= 1'b0;
            frame_done_out  <= 1'b0;
            credit_overflow <= 1'b0;
        end else begin
            state          <= state_next;
            credits_out    <= credits_next;
            valid_out      <= issue;
            busy_out       <= (state != IDLE);
            frame_done_out <= (state == DRAIN) && cred_full;
            if (overflow_hit)
                credit_overflow <= 1'b1;

            if (state == IDLE && restart) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (issue) begin
                x_out <= x_cnt;
                y_out <= y_cnt;
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 10'd1;
                end else begin
                    x_cnt <= x_cnt + 11'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_issuer.sv
// Scoreboard bench for pixel_scan_issuer: a frame-level model predicts pixels, credits and
// frame completion while a negedge monitor compares against the DUT outputs.
module tb_pixel_scan_issuer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int M = 4;
`ifdef PIXEL_SCAN_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, credit;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid, busy, done;
    logic [7:0]  cred;

    always #5 clk = ~clk;

    pixel_scan_issuer #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(M)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .credit_in(credit),
        .x_out(x), .y_out(y), .valid_out(valid), .busy_out(busy),
        .frame_done_out(done), .credits_out(cred)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: frame phase, free credits, pixels issued this frame.
    int ph;           // 0 idle, 1 scanning, 2 draining
    int mcred, missued;
    bit m_valid, m_busy, m_done, armed = 1'b0;
    bit m_iss, m_dn;
    int exp_x, exp_y, p;
    int pq[$];
    int done_seen = 0;
    int cyc = 0;
    int last_done_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (armed) begin
            check("valid", int'(valid), int'(m_valid));
            if (m_valid) begin
                if (pq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pixel_queue actual=empty required=pending pixel at %0t", $time);
                end else begin
                    p = pq.pop_front();
                    exp_x = p / 1024;
                    exp_y = p % 1024;
                end
            end
            check("x", int'(x), exp_x);
            check("y", int'(y), exp_y);
            check("credits", int'(cred), mcred);
            check("busy", int'(busy), int'(m_busy));
            check("frame_done", int'(done), int'(m_done));
`ifdef PIXEL_SCAN_LOOP_EN
            if (valid && x == 0 && y == 0 && last_done_cyc >= 0) begin
                check("loop_gap", cyc - last_done_cyc, 2);
                last_done_cyc = -1;
            end
`endif
        end
        if (done) begin
            done_seen++;
            last_done_cyc = cyc;
        end

        if (rst) begin
            armed = 1'b1;
            ph = 0; mcred = M; missued = 0;
            m_valid = 0; m_busy = 0; m_done = 0;
            exp_x = 0; exp_y = 0;
            pq.delete();
            last_done_cyc = -1;
        end else if (armed) begin
            m_iss  = (ph == 1) && (mcred > 0);
            m_dn   = (ph == 2) && (mcred == M);
            m_busy = (ph != 0);
            if (m_iss && !credit) mcred--;
            else if (!m_iss && credit && mcred < M) mcred++;
            case (ph)
                0: if (start || (LOOP && m_done)) begin
                    ph = 1;
                    missued = 0;
                    for (int yy = 0; yy < H; yy++)
                        for (int xx = 0; xx < W; xx++)
                            pq.push_back(xx * 1024 + yy);
                end
                1: if (m_iss) begin
                    missued++;
                    if (missued == W * H) ph = 2;
                end
                default: if (m_dn) ph = 0;
            endcase
            m_valid = m_iss;
            m_done  = m_dn;
        end
    end

    // Stimulus: credit return modes 0 none, 1 echo of valid delayed, 2 random from pending.
    int       cmode = 0;
    int       pend = 0;
    bit [7:0] vhist = '0;

    task automatic step();
        @(posedge clk);
        #1;
        vhist = {vhist[6:0], valid};
        if (valid) pend++;
        case (cmode)
            1:       credit = vhist[5];
            2:       credit = (pend > 0) && ($urandom_range(0, 2) != 0);
            default: credit = 1'b0;
        endcase
        if (credit) pend--;
    endtask

    task automatic do_reset();
        cmode = 0;
        rst = 1'b1;
        start = 1'b0;
        step();
        step();
        rst = 1'b0;
        pend = 0;
        vhist = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_seen;
        int n = 0;
        while (done_seen == d0 && n < budget) begin
            step();
            n++;
        end
        check("frame_done_seen", int'(done_seen != d0), 1);
    endtask

    int nv;
    int n;

    initial begin
        rst = 1'b0; start = 1'b0; credit = 1'b0;

        do_reset();
        repeat (10) step();
        check("idle_credits", int'(cred), M);
        check("idle_valid", int'(valid), 0);

        // Full frame with credits echoed back
        cmode = 1;
        pulse_start();
        wait_done(300);
        check("frame_queue_drained", pq.size(), 0);

        // Starvation then single-credit release
        do_reset();
        pulse_start();
        nv = 0;
        repeat (15) begin
            step();
            nv += int'(valid);
        end
        check("starve_issued", nv, M);
        check("starve_credits", int'(cred), 0);
        check("starve_valid", int'(valid), 0);
        credit = 1'b1;
        pend--;
        step();
        check("release_credit", int'(cred), 1);
        step();
        check("release_valid", int'(valid), 1);
        step();
        check("release_once", int'(valid), 0);
        cmode = 2;
        wait_done(500);

        // Issue and return in the same cycle at two credits
        do_reset();
        pulse_start();
        n = 0;
        while (cred != 8'd2 && n < 10) begin
            step();
            n++;
        end
        check("reach_two_credits", int'(cred), 2);
        credit = 1'b1;
        pend--;
        step();
        check("simul_credits", int'(cred), 2);
        check("simul_valid", int'(valid), 1);
        cmode = 2;
        wait_done(500);

        // Reset at pixel (2,1), stray credits, then ignored starts mid-scan
        do_reset();
        cmode = 2;
        pulse_start();
        n = 0;
        while (!(valid && x == 11'd2 && y == 10'd1) && n < 200) begin
            step();
            n++;
        end
        check("reached_pixel_2_1", int'(valid && x == 11'd2 && y == 10'd1), 1);
        cmode = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        pend = 0;
        step();
        check("midreset_busy", int'(busy), 0);
        check("midreset_credits", int'(cred), M);
        credit = 1'b1;
        step();
        credit = 1'b1;
        step();
        check("overflow_saturates", int'(cred), M);
        cmode = 2;
        pulse_start();
        n = 0;
        begin
            int d0 = done_seen;
            while (done_seen == d0 && n < 500) begin
                start = ($urandom_range(0, 3) == 0);
                step();
                n++;
            end
            start = 1'b0;
            check("ignored_start_frame_done", int'(done_seen != d0), 1);
        end

        // Randomized frames with random start gaps
        for (int f = 0; f < 3; f++) begin
            do_reset();
            repeat ($urandom_range(0, 5)) step();
            cmode = 2;
            pulse_start();
            wait_done(500);
            if (LOOP) begin
                repeat (6) step();
            end
        end
        do_reset();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
